// File: rtl/float_param_pkg.sv
// Shared definitions for the parametrised float arithmetic blocks:
// FSM encoding, flag positions, field-width helpers and the canonical quiet NaN.
package float_param_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_UNPACK, S_SPECIAL, S_NORM_IN, S_MULT, S_EXTRACT,
    S_NORM_OUT, S_DENORM, S_ROUND, S_PACK, S_PUT_Z
  } state_t;

  localparam int FLG_NV = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;

  function automatic int f_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int f_word_w(input int exp_w, input int man_w);
    return exp_w + man_w + 1;
  endfunction

  // signed internal exponent: two spare bits cover the product/denorm range
  function automatic int f_iexp_w(input int exp_w);
    return exp_w + 2;
  endfunction

  function automatic logic [63:0] f_qnan(input int exp_w, input int man_w);
    return (64'd1 << (exp_w + man_w)) |
           (((64'd1 << exp_w) - 64'd1) << man_w) |
           (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/float_round_rne.sv
// Combinational round-to-nearest-even on a hidden-bit mantissa with guard/round/sticky.
module float_round_rne #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [MAN_W:0]         i_man,
  input  logic signed [EXP_W+1:0] i_exp,
  input  logic                   i_guard,
  input  logic                   i_round,
  input  logic                   i_sticky,
  output logic [MAN_W:0]         o_man,
  output logic signed [EXP_W+1:0] o_exp,
  output logic                   o_nx
);
  localparam logic signed [EXP_W+1:0] ONE_E = 1;

  logic             w_up;
  logic [MAN_W+1:0] w_sum;

  assign w_up  = i_guard & (i_round | i_sticky | i_man[0]);
  assign w_sum = {1'b0, i_man} + {{(MAN_W+1){1'b0}}, w_up};
  // carry-out means the mantissa wrapped to 10..0: renormalise one place
  assign o_man = w_sum[MAN_W+1] ? w_sum[MAN_W+1:1] : w_sum[MAN_W:0];
  assign o_exp = w_sum[MAN_W+1] ? i_exp + ONE_E : i_exp;
  assign o_nx  = i_guard | i_round | i_sticky;

endmodule

// File: rtl/float_mult_param.sv
// Multi-cycle IEEE-754 style multiplier, generic in exponent/mantissa width,
// RNE rounding, exception flags, optional flush-to-zero, STB/ACK handshake.
module float_mult_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int FTZ   = 0
) (
  input  logic                   i_CLK,
  input  logic                   i_RST,
  input  logic [EXP_W+MAN_W:0]   i_A,
  input  logic [EXP_W+MAN_W:0]   i_B,
  input  logic                   i_AB_STB,
  output logic                   o_AB_ACK,
  output logic [EXP_W+MAN_W:0]   o_Z,
  output logic                   o_Z_STB,
  input  logic                   i_Z_ACK,
  output logic [3:0]             o_FLAGS
);
  import float_param_pkg::*;

  localparam int W    = f_word_w(EXP_W, MAN_W);
  localparam int IW   = f_iexp_w(EXP_W);
  localparam int PW   = 2 * (MAN_W + 1);
  localparam int BIAS = f_bias(EXP_W);

  localparam logic signed [IW-1:0] BIAS_E = IW'(BIAS);
  localparam logic signed [IW-1:0] E_MIN  = IW'(1 - BIAS);
  localparam logic signed [IW-1:0] E_ZERO = IW'(-BIAS);
  localparam logic signed [IW-1:0] E_SPEC = IW'(BIAS + 1);
  localparam logic signed [IW-1:0] ONE_E  = 1;
  localparam logic [EXP_W-1:0]     BIAS_F = EXP_W'(BIAS);
  localparam logic [W-1:0]         QNAN   = W'(f_qnan(EXP_W, MAN_W));

  state_t                r_state;
  logic                  r_ab_ack, r_z_stb;
  logic [W-1:0]          r_z, r_a, r_b, r_spec_z;
  logic [3:0]            r_flags;
  logic                  r_sa, r_sb, r_sz, r_spec, r_spec_nv;
  logic [MAN_W:0]        r_ma, r_mb, r_mz;
  logic signed [IW-1:0]  r_ea, r_eb, r_ez;
  logic [PW-1:0]         r_prod;
  logic                  r_g, r_r, r_s, r_nx;

  logic                  w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero, w_sx;
  logic [MAN_W:0]        w_rnd_man;
  logic signed [IW-1:0]  w_rnd_exp;
  logic                  w_rnd_nx, w_tiny;
  logic [EXP_W-1:0]      w_exp_f;
  logic [W-1:0]          w_pack_z;
  logic [3:0]            w_pack_fl;

  assign o_AB_ACK = r_ab_ack;
  assign o_Z_STB  = r_z_stb;
  assign o_Z      = r_z;
  assign o_FLAGS  = r_flags;

  // exponent field all ones unbiases to bias+1; all zeros to -bias
  assign w_sx     = r_sa ^ r_sb;
  assign w_a_nan  = (r_ea == E_SPEC) &&  (|r_ma[MAN_W-1:0]);
  assign w_b_nan  = (r_eb == E_SPEC) &&  (|r_mb[MAN_W-1:0]);
  assign w_a_inf  = (r_ea == E_SPEC) && !(|r_ma[MAN_W-1:0]);
  assign w_b_inf  = (r_eb == E_SPEC) && !(|r_mb[MAN_W-1:0]);
  assign w_a_zero = (r_ea == E_ZERO) && ((FTZ != 0) || !(|r_ma[MAN_W-1:0]));
  assign w_b_zero = (r_eb == E_ZERO) && ((FTZ != 0) || !(|r_mb[MAN_W-1:0]));

  float_round_rne #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_rnd (
    .i_man   (r_mz),
    .i_exp   (r_ez),
    .i_guard (r_g),
    .i_round (r_r),
    .i_sticky(r_s),
    .o_man   (w_rnd_man),
    .o_exp   (w_rnd_exp),
    .o_nx    (w_rnd_nx)
  );

  // a result without its hidden bit after rounding is subnormal, i.e. tiny
  always_comb begin
    w_tiny    = ~r_mz[MAN_W];
    w_exp_f   = r_ez[EXP_W-1:0] + BIAS_F;
    w_pack_fl = 4'b0000;
    w_pack_z  = {r_sz, (w_tiny ? {EXP_W{1'b0}} : w_exp_f), r_mz[MAN_W-1:0]};
    if (r_ez > BIAS_E) begin
      w_pack_z          = {r_sz, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_pack_fl[FLG_OF] = 1'b1;
      w_pack_fl[FLG_NX] = 1'b1;
    end else if (w_tiny && (FTZ != 0)) begin
      w_pack_z          = {r_sz, {(W-1){1'b0}}};
      w_pack_fl[FLG_UF] = 1'b1;
      w_pack_fl[FLG_NX] = 1'b1;
    end else begin
      w_pack_fl[FLG_UF] = w_tiny & r_nx;
      w_pack_fl[FLG_NX] = r_nx;
    end
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_state   <= S_IDLE;
      r_ab_ack  <= 1'b0;
      r_z_stb   <= 1'b0;
      r_z       <= '0;
      r_flags   <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_spec_z  <= '0;
      r_sa      <= 1'b0;
      r_sb      <= 1'b0;
      r_sz      <= 1'b0;
      r_spec    <= 1'b0;
      r_spec_nv <= 1'b0;
      r_ma      <= '0;
      r_mb      <= '0;
      r_mz      <= '0;
      r_ea      <= '0;
      r_eb      <= '0;
      r_ez      <= '0;
      r_prod    <= '0;
      r_g       <= 1'b0;
      r_r       <= 1'b0;
      r_s       <= 1'b0;
      r_nx      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ab_ack <= 1'b1;
          if (r_ab_ack && i_AB_STB) begin
            r_a      <= i_A;
            r_b      <= i_B;
            r_ab_ack <= 1'b0;
            r_spec   <= 1'b0;
            r_state  <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          r_sa    <= r_a[W-1];
          r_sb    <= r_b[W-1];
          r_ma    <= {1'b0, r_a[MAN_W-1:0]};
          r_mb    <= {1'b0, r_b[MAN_W-1:0]};
          r_ea    <= $signed({2'b00, r_a[W-2:MAN_W]}) - BIAS_E;
          r_eb    <= $signed({2'b00, r_b[W-2:MAN_W]}) - BIAS_E;
          r_state <= S_SPECIAL;
        end
        S_SPECIAL: begin
          r_spec_nv <= 1'b0;
          if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_a_zero && w_b_inf)) begin
            r_spec_z  <= QNAN;
            r_spec_nv <= 1'b1;
            r_spec    <= 1'b1;
            r_state   <= S_PACK;
          end else if (w_a_inf || w_b_inf) begin
            r_spec_z <= {w_sx, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            r_spec   <= 1'b1;
            r_state  <= S_PACK;
          end else if (w_a_zero || w_b_zero) begin
            r_spec_z <= {w_sx, {(W-1){1'b0}}};
            r_spec   <= 1'b1;
            r_state  <= S_PACK;
          end else begin
            if (r_ea == E_ZERO) r_ea <= E_MIN;
            else                r_ma[MAN_W] <= 1'b1;
            if (r_eb == E_ZERO) r_eb <= E_MIN;
            else                r_mb[MAN_W] <= 1'b1;
            r_state <= S_NORM_IN;
          end
        end
        S_NORM_IN: begin
          if (r_ma[MAN_W] && r_mb[MAN_W]) begin
            r_state <= S_MULT;
          end else begin
            if (!r_ma[MAN_W]) begin
              r_ma <= r_ma << 1;
              r_ea <= r_ea - ONE_E;
            end
            if (!r_mb[MAN_W]) begin
              r_mb <= r_mb << 1;
              r_eb <= r_eb - ONE_E;
            end
          end
        end
        S_MULT: begin
          r_sz    <= w_sx;
          r_ez    <= r_ea + r_eb + ONE_E;
          r_prod  <= PW'(r_ma) * PW'(r_mb);
          r_state <= S_EXTRACT;
        end
        S_EXTRACT: begin
          r_mz    <= r_prod[PW-1:MAN_W+1];
          r_g     <= r_prod[MAN_W];
          r_r     <= r_prod[MAN_W-1];
          r_s     <= |r_prod[MAN_W-2:0];
          r_state <= S_NORM_OUT;
        end
        S_NORM_OUT: begin
          // shift and exit in the same cycle once the shifted MSB will be set
          if (!r_mz[MAN_W]) begin
            r_mz <= {r_mz[MAN_W-1:0], r_g};
            r_g  <= r_r;
            r_r  <= 1'b0;
            r_ez <= r_ez - ONE_E;
          end
          if (r_mz[MAN_W] || r_mz[MAN_W-1]) r_state <= S_DENORM;
        end
        S_DENORM: begin
          if (r_ez < E_MIN) begin
            r_mz <= r_mz >> 1;
            r_g  <= r_mz[0];
            r_r  <= r_g;
            r_s  <= r_s | r_r;
            r_ez <= r_ez + ONE_E;
          end else begin
            r_state <= S_ROUND;
          end
        end
        S_ROUND: begin
          r_mz    <= w_rnd_man;
          r_ez    <= w_rnd_exp;
          r_nx    <= w_rnd_nx;
          r_state <= S_PACK;
        end
        S_PACK: begin
          if (r_spec) begin
            r_z     <= r_spec_z;
            r_flags <= {r_spec_nv, 3'b000};
          end else begin
            r_z     <= w_pack_z;
            r_flags <= w_pack_fl;
          end
          r_z_stb <= 1'b1;
          r_state <= S_PUT_Z;
        end
        S_PUT_Z: begin
          if (i_Z_ACK) begin
            r_z_stb  <= 1'b0;
            r_ab_ack <= 1'b1;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_float_mult_param.sv
// Directed-vector bench: single precision, single precision with FTZ, half precision.
module tb_float_mult_param;

  logic        clk, rst;
  logic [31:0] a, b;
  logic        stb [3];
  logic        zack [3];
  logic        w_ack [3];
  logic        w_zstb [3];
  logic [31:0] w_z [3];
  logic [3:0]  w_fl [3];
  logic [31:0] w_zs, w_zf;
  logic [15:0] w_zh;
  int          n_tot, n_bad;

  assign w_z[0] = w_zs;
  assign w_z[1] = w_zf;
  assign w_z[2] = {16'h0000, w_zh};

  float_mult_param #(.EXP_W(8), .MAN_W(23), .FTZ(0)) u_sp (
    .i_CLK(clk), .i_RST(rst), .i_A(a), .i_B(b), .i_AB_STB(stb[0]), .o_AB_ACK(w_ack[0]),
    .o_Z(w_zs), .o_Z_STB(w_zstb[0]), .i_Z_ACK(zack[0]), .o_FLAGS(w_fl[0]));

  float_mult_param #(.EXP_W(8), .MAN_W(23), .FTZ(1)) u_ftz (
    .i_CLK(clk), .i_RST(rst), .i_A(a), .i_B(b), .i_AB_STB(stb[1]), .o_AB_ACK(w_ack[1]),
    .o_Z(w_zf), .o_Z_STB(w_zstb[1]), .i_Z_ACK(zack[1]), .o_FLAGS(w_fl[1]));

  float_mult_param #(.EXP_W(5), .MAN_W(10), .FTZ(0)) u_hp (
    .i_CLK(clk), .i_RST(rst), .i_A(a[15:0]), .i_B(b[15:0]), .i_AB_STB(stb[2]), .o_AB_ACK(w_ack[2]),
    .o_Z(w_zh), .o_Z_STB(w_zstb[2]), .i_Z_ACK(zack[2]), .o_FLAGS(w_fl[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic launch(input int d, input logic [31:0] av, input logic [31:0] bv, input string tag);
    int n;
    n = 0;
    while (!w_ack[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_abak"}, {31'd0, w_ack[d]}, 32'd1);
    a = av;
    b = bv;
    stb[d] = 1'b1;
    @(posedge clk);
    #1 stb[d] = 1'b0;
  endtask

  task automatic wait_z(input int d, input int exp_lat, input string tag);
    int lat;
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!w_zstb[d] && lat < 400);
    chk({tag, "_zstb"}, {31'd0, w_zstb[d]}, 32'd1);
    if (exp_lat > 0) chk({tag, "_lat"}, lat, exp_lat);
  endtask

  task automatic ack_z(input int d, input string tag);
    @(negedge clk);
    zack[d] = 1'b1;
    @(posedge clk);
    #1 zack[d] = 1'b0;
    chk({tag, "_zstb_drop"}, {31'd0, w_zstb[d]}, 32'd0);
    chk({tag, "_abak_rise"}, {31'd0, w_ack[d]}, 32'd1);
  endtask

  task automatic op(input int d, input logic [31:0] av, input logic [31:0] bv,
                    input logic [31:0] ez, input logic [3:0] efl, input int elat, input string tag);
    launch(d, av, bv, tag);
    wait_z(d, elat, tag);
    @(negedge clk);
    chk({tag, "_z"}, w_z[d], ez);
    chk({tag, "_flags"}, {28'd0, w_fl[d]}, {28'd0, efl});
    ack_z(d, tag);
  endtask

  initial begin
    n_tot = 0;
    n_bad = 0;
    a = '0;
    b = '0;
    for (int i = 0; i < 3; i++) begin
      stb[i]  = 1'b0;
      zack[i] = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("rst_abak",  {31'd0, w_ack[0]},  32'd0);
    chk("rst_zstb",  {31'd0, w_zstb[0]}, 32'd0);
    chk("rst_z",     w_z[0], 32'd0);
    chk("rst_flags", {28'd0, w_fl[0]}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 chk("rst_abak_rise", {31'd0, w_ack[0]}, 32'd1);

    // single precision
    op(0, 32'h40400000, 32'h40200000, 32'h40F00000, 4'b0000, 9, "m3x2p5");
    op(0, 32'h7F800000, 32'h00000000, 32'hFFC00000, 4'b1000, 3, "infx0");
    op(0, 32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'b0101, 9, "ovf");
    op(0, 32'h00000003, 32'h3F000000, 32'h00000002, 4'b0011, 0, "tie_even");
    op(0, 32'hC0000000, 32'h7F800000, 32'hFF800000, 4'b0000, 3, "ninf");
    op(0, 32'h80000000, 32'h40400000, 32'h80000000, 4'b0000, 3, "nzero");
    op(0, 32'h7FC00001, 32'h3F800000, 32'hFFC00000, 4'b1000, 3, "nan_in");
    // flush-to-zero: subnormal input reads as zero
    op(1, 32'h00000003, 32'h3F000000, 32'h00000000, 4'b0000, 3, "ftz");
    // half precision
    op(2, 32'h00003E00, 32'h00003E00, 32'h00004080, 4'b0000, 9, "h1p5sq");
    op(2, 32'h00003C00, 32'h0000BC00, 32'h0000BC00, 4'b0000, 9, "h1xm1");

    // back-pressure: result held, new operands ignored
    launch(0, 32'h3FC00000, 32'h40000000, "bp");
    wait_z(0, 9, "bp");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_z",     w_z[0], 32'h40400000);
      chk("bp_flags", {28'd0, w_fl[0]}, 32'd0);
      chk("bp_zstb",  {31'd0, w_zstb[0]}, 32'd1);
      chk("bp_abak",  {31'd0, w_ack[0]}, 32'd0);
      stb[0] = i[0];
      a = $urandom;
    end
    stb[0] = 1'b0;
    ack_z(0, "bp");
    op(0, 32'h40400000, 32'h40200000, 32'h40F00000, 4'b0000, 9, "after_bp");

    // asynchronous reset while normalising a subnormal input
    launch(0, 32'h00000003, 32'h3F000000, "rst_mid");
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rstm_abak",  {31'd0, w_ack[0]},  32'd0);
    chk("rstm_zstb",  {31'd0, w_zstb[0]}, 32'd0);
    chk("rstm_z",     w_z[0], 32'd0);
    chk("rstm_flags", {28'd0, w_fl[0]}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 chk("rstm_abak_rise", {31'd0, w_ack[0]}, 32'd1);
    chk("rstm_no_zstb", {31'd0, w_zstb[0]}, 32'd0);
    op(0, 32'h40400000, 32'h40200000, 32'h40F00000, 4'b0000, 9, "after_rst");

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
